// File: rtl/ipg_rx_extract_if.sv
// Block stream and memory-chunk FIFO signals for the RX IPG extractor.
// The master modport is the side that supplies rx blocks and pops chunks; slave is the extractor.
interface ipg_rx_extract_if #(
    parameter int SPACE_W = 4,
    parameter int CNT_W   = 16
);
    logic [63:0]        rx_data;
    logic [1:0]         rx_hdr;
    logic               rx_valid;
    logic [63:0]        net_data;
    logic [1:0]         net_hdr;
    logic               net_valid;
    logic               netfin;
    logic               mem_rd;
    logic [63:0]        mem_data;
    logic               mem_empty;
    logic               mem_full;
    logic [SPACE_W-1:0] mem_space;
    logic [CNT_W-1:0]   mem_drop_cnt;
    logic [CNT_W-1:0]   hdr_err_cnt;

    modport master (
        output rx_data, rx_hdr, rx_valid, mem_rd,
        input  net_data, net_hdr, net_valid, netfin,
        input  mem_data, mem_empty, mem_full, mem_space, mem_drop_cnt, hdr_err_cnt
    );

    modport slave (
        input  rx_data, rx_hdr, rx_valid, mem_rd,
        output net_data, net_hdr, net_valid, netfin,
        output mem_data, mem_empty, mem_full, mem_space, mem_drop_cnt, hdr_err_cnt
    );
endinterface

// File: rtl/ipg_rx_extract.sv
// RX-side IPG extractor: data blocks seen between frames are memory-reply chunks; they are
// moved into a FWFT FIFO and replaced by an idle control block so the MAC sees a normal gap.
module ipg_rx_extract #(
    parameter int DEPTH   = 8,
    parameter int SPACE_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    ipg_rx_extract_if.slave  bus
);
    localparam int          PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  SYNC_DATA = 2'b10;
    localparam logic [1:0]  SYNC_CTRL = 2'b01;
    localparam logic [63:0] IDLE_BLK  = 64'h0000_0000_0000_001e;

    typedef enum logic {GAP, FRAME} state_t;

    state_t             state;
    logic [63:0]        net_data_q;
    logic [1:0]         net_hdr_q;
    logic               net_valid_q;
    logic               netfin_q;
    logic [CNT_W-1:0]   drop_cnt_q;
    logic [CNT_W-1:0]   err_cnt_q;

    logic [63:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [SPACE_W-1:0] count_q;
    logic [SPACE_W-1:0] count_nxt;
    logic [SPACE_W-1:0] space_q;
    logic               full_q;
    logic               empty_q;

    logic [7:0] blk_type;
    logic       is_ctrl;
    logic       is_data;
    logic       hdr_bad;
    logic       is_start;
    logic       is_term;
    logic       chunk;
    logic       push;
    logic       pop;
    logic       drop;
    logic       err_inc;

    always_comb begin
        blk_type = bus.rx_data[7:0];
        is_ctrl  = (bus.rx_hdr == SYNC_CTRL);
        is_data  = (bus.rx_hdr == SYNC_DATA);
        hdr_bad  = (bus.rx_hdr == 2'b00) || (bus.rx_hdr == 2'b11);
        is_start = 1'b0;
        is_term  = 1'b0;
        if (is_ctrl) begin
            case (blk_type)
                8'h78, 8'h33, 8'h66: is_start = 1'b1;
                8'h87, 8'h99, 8'haa, 8'hb4,
                8'hcc, 8'hd2, 8'he1, 8'hff: is_term = 1'b1;
                default: ;
            endcase
        end
        chunk   = bus.rx_valid && (state == GAP) && is_data;
        pop     = bus.mem_rd && !empty_q;
        // A full FIFO still accepts a chunk when the head leaves in the same cycle.
        push    = chunk && (!full_q || pop);
        drop    = chunk && full_q && !pop;
        err_inc = bus.rx_valid && (hdr_bad || ((state == FRAME) && is_start));
        count_nxt = count_q + SPACE_W'(push) - SPACE_W'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= GAP;
            net_data_q  <= '0;
            net_hdr_q   <= '0;
            net_valid_q <= 1'b0;
            netfin_q    <= 1'b0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            net_valid_q <= bus.rx_valid;
            netfin_q    <= bus.rx_valid && is_term;
            if (bus.rx_valid) begin
                if (chunk) begin
                    net_hdr_q  <= SYNC_CTRL;
                    net_data_q <= IDLE_BLK;
                end else begin
                    net_hdr_q  <= bus.rx_hdr;
                    net_data_q <= bus.rx_data;
                end
                // A corrupted header means frame tracking can no longer be trusted.
                if (hdr_bad)
                    state <= GAP;
                else if ((state == GAP) && is_start)
                    state <= FRAME;
                else if ((state == FRAME) && is_term)
                    state <= GAP;
            end
            if (drop && (drop_cnt_q != {CNT_W{1'b1}}))
                drop_cnt_q <= drop_cnt_q + 1'b1;
            if (err_inc && (err_cnt_q != {CNT_W{1'b1}}))
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            space_q <= SPACE_W'(DEPTH);
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_nxt;
            space_q <= SPACE_W'(DEPTH) - count_nxt;
            full_q  <= (count_nxt == SPACE_W'(DEPTH));
            empty_q <= (count_nxt == '0);
        end
    end

    // Storage needs no reset; empty_q masks stale entries from the head output.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.rx_data;
    end

    assign bus.net_data     = net_data_q;
    assign bus.net_hdr      = net_hdr_q;
    assign bus.net_valid    = net_valid_q;
    assign bus.netfin       = netfin_q;
    assign bus.mem_data     = empty_q ? 64'd0 : mem[rd_ptr];
    assign bus.mem_empty    = empty_q;
    assign bus.mem_full     = full_q;
    assign bus.mem_space    = space_q;
    assign bus.mem_drop_cnt = drop_cnt_q;
    assign bus.hdr_err_cnt  = err_cnt_q;
endmodule
